// File: rtl/menu_cursor_ctrl_if.sv
// Menu cursor bus: button levels and pixel coordinate in, cursor and
// selection state out. The master drives the inputs, the cursor block
// is the slave.
interface menu_cursor_ctrl_if #(
    parameter int IDX_W = 2
);
    logic             video_on;
    logic             btn_up;
    logic             btn_down;
    logic             btn_sel;
    logic             btn_back;
    logic [9:0]       pix_x;
    logic [9:0]       pix_y;
    logic [2:0]       cursor_rgb;
    logic             cursor_on;
    logic [IDX_W-1:0] nivel;
    logic             sel_valid;
    logic             locked;

    modport master (
        output video_on, btn_up, btn_down, btn_sel, btn_back, pix_x, pix_y,
        input  cursor_rgb, cursor_on, nivel, sel_valid, locked
    );

    modport slave (
        input  video_on, btn_up, btn_down, btn_sel, btn_back, pix_x, pix_y,
        output cursor_rgb, cursor_on, nivel, sel_valid, locked
    );
endinterface

// File: rtl/menu_cursor_ctrl.sv
// Menu selection cursor: moves an index over N_ITEMS stacked entries on
// button presses, latches a confirmed choice, and draws a cross-shaped
// cursor at the selected entry (one-cycle registered pixel path).
module menu_cursor_ctrl #(
    parameter int          N_ITEMS    = 3,
    parameter int          IDX_W      = 2,
    parameter int          X0         = 161,
    parameter int          Y0         = 302,
    parameter int          Y_STEP     = 32,
    parameter bit          WRAP       = 1'b1,
    parameter logic [2:0]  BROWSE_RGB = 3'b100,
    parameter logic [2:0]  SEL_RGB    = 3'b010
) (
    input  logic              clk,
    input  logic              reset,
    menu_cursor_ctrl_if.slave bus
);

    localparam int Y_LAST = Y0 + (N_ITEMS - 1) * Y_STEP;

    // Shape extents reach 10 pixels from the centre; every bound must fit 0..1023.
    if ((N_ITEMS < 2) || (N_ITEMS > 16) || ((2 ** IDX_W) < N_ITEMS) ||
        (X0 < 10) || (X0 + 10 > 1023) || (Y0 < 10) || (Y_STEP < 0) ||
        (Y_LAST + 10 > 1023)) begin : g_bad_params
        $error("menu_cursor_ctrl: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        ST_BROWSE    = 1'b0,
        ST_CONFIRMED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ITEMS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic             up_prev_r;
    logic             down_prev_r;
    logic             sel_prev_r;
    logic             back_prev_r;
    logic             sel_valid_r;
    logic             locked_r;
    logic             cursor_on_r;
    logic [2:0]       cursor_rgb_r;

    logic             up_ev_s;
    logic             down_ev_s;
    logic             sel_ev_s;
    logic             back_ev_s;
    logic [IDX_W-1:0] idx_up_s;
    logic [IDX_W-1:0] idx_down_s;
    logic [10:0]      cy_s;
    logic             hit_s;

    // Cross = vertical bar, horizontal bar and centre square, all inclusive.
    function automatic logic shape_hit(input logic [10:0] px, input logic [10:0] py,
                                       input logic [10:0] cx, input logic [10:0] cy);
        logic [10:0] dx;
        logic [10:0] dy;
        dx = (px >= cx) ? (px - cx) : (cx - px);
        dy = (py >= cy) ? (py - cy) : (cy - py);
        return ((dx <= 11'd5)  && (dy <= 11'd10)) ||
               ((dx <= 11'd10) && (dy <= 11'd5))  ||
               ((dx <= 11'd7)  && (dy <= 11'd7));
    endfunction

    assign up_ev_s   = bus.btn_up   & ~up_prev_r;
    assign down_ev_s = bus.btn_down & ~down_prev_r;
    assign sel_ev_s  = bus.btn_sel  & ~sel_prev_r;
    assign back_ev_s = bus.btn_back & ~back_prev_r;

    // Neighbour indices at the list ends: wrap around or stay put.
    always_comb begin
        idx_up_s   = idx_r;
        idx_down_s = idx_r;
        if (idx_r == IDX_ZERO) begin
            idx_up_s = WRAP ? IDX_LAST : IDX_ZERO;
        end else begin
            idx_up_s = idx_r - IDX_W'(1);
        end
        if (idx_r >= IDX_LAST) begin
            idx_down_s = WRAP ? IDX_ZERO : IDX_LAST;
        end else begin
            idx_down_s = idx_r + IDX_W'(1);
        end
    end

    assign cy_s  = 11'(Y0) + (11'(idx_r) * 11'(Y_STEP));
    assign hit_s = shape_hit({1'b0, bus.pix_x}, {1'b0, bus.pix_y}, 11'(X0), cy_s);

    // Previous button levels; held high through reset so a held button needs a re-press.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_prev_r   <= 1'b1;
            down_prev_r <= 1'b1;
            sel_prev_r  <= 1'b1;
            back_prev_r <= 1'b1;
        end else begin
            up_prev_r   <= bus.btn_up;
            down_prev_r <= bus.btn_down;
            sel_prev_r  <= bus.btn_sel;
            back_prev_r <= bus.btn_back;
        end
    end

    // Browse/confirm FSM with index, confirm pulse and lock flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_BROWSE;
            idx_r       <= IDX_ZERO;
            sel_valid_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            sel_valid_r <= 1'b0;
            case (state_r)
                ST_BROWSE: begin
                    if (sel_ev_s) begin
                        state_r     <= ST_CONFIRMED;
                        sel_valid_r <= 1'b1;
                        locked_r    <= 1'b1;
                    end else if (up_ev_s && down_ev_s) begin
                        idx_r <= idx_r;
                    end else if (up_ev_s) begin
                        idx_r <= idx_up_s;
                    end else if (down_ev_s) begin
                        idx_r <= idx_down_s;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_CONFIRMED: begin
                    if (back_ev_s) begin
                        state_r  <= ST_BROWSE;
                        locked_r <= 1'b0;
                    end else begin
                        state_r  <= ST_CONFIRMED;
                        locked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_BROWSE;
                    idx_r    <= IDX_ZERO;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered pixel path: cursor coverage and colour for the RGB mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_on_r  <= 1'b0;
            cursor_rgb_r <= 3'b000;
        end else begin
            cursor_on_r <= hit_s;
            if (bus.video_on && hit_s) begin
                cursor_rgb_r <= (state_r == ST_CONFIRMED) ? SEL_RGB : BROWSE_RGB;
            end else begin
                cursor_rgb_r <= 3'b000;
            end
        end
    end

    assign bus.nivel      = idx_r;
    assign bus.locked     = locked_r;
    assign bus.sel_valid  = sel_valid_r;
    assign bus.cursor_on  = cursor_on_r;
    assign bus.cursor_rgb = cursor_rgb_r;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Bench for menu_cursor_ctrl: three instances (wrap N=3, saturate N=3,
// wrap N=5 with pitch 20) share one stimulus stream and are each checked
// every cycle against a behavioural model, plus hand-derived tables.
module tb_menu_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on, btn_up, btn_down, btn_sel, btn_back;
    logic [9:0] pix_x, pix_y;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    menu_cursor_ctrl_if #(.IDX_W(2)) ifa ();
    menu_cursor_ctrl_if #(.IDX_W(2)) ifb ();
    menu_cursor_ctrl_if #(.IDX_W(3)) ifc ();

    assign ifa.video_on = video_on;  assign ifb.video_on = video_on;  assign ifc.video_on = video_on;
    assign ifa.btn_up   = btn_up;    assign ifb.btn_up   = btn_up;    assign ifc.btn_up   = btn_up;
    assign ifa.btn_down = btn_down;  assign ifb.btn_down = btn_down;  assign ifc.btn_down = btn_down;
    assign ifa.btn_sel  = btn_sel;   assign ifb.btn_sel  = btn_sel;   assign ifc.btn_sel  = btn_sel;
    assign ifa.btn_back = btn_back;  assign ifb.btn_back = btn_back;  assign ifc.btn_back = btn_back;
    assign ifa.pix_x    = pix_x;     assign ifb.pix_x    = pix_x;     assign ifc.pix_x    = pix_x;
    assign ifa.pix_y    = pix_y;     assign ifb.pix_y    = pix_y;     assign ifc.pix_y    = pix_y;

    menu_cursor_ctrl #(.N_ITEMS(3), .IDX_W(2), .Y_STEP(32), .WRAP(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    menu_cursor_ctrl #(.N_ITEMS(3), .IDX_W(2), .Y_STEP(32), .WRAP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    menu_cursor_ctrl #(.N_ITEMS(5), .IDX_W(3), .Y_STEP(20), .WRAP(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int   n;
        int   ystep;
        bit   wrap;
        int   idx;
        bit   locked;
        bit   prev_up, prev_dn, prev_sel, prev_bk;
        bit   e_sv;
        bit   e_on;
        int   e_rgb;
    } mdl_t;

    mdl_t m [3];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit cross_hit(input int px, input int py, input int cx, input int cy);
        int dx, dy;
        dx = iabs(px - cx);
        dy = iabs(py - cy);
        return (dx <= 5 && dy <= 10) || (dx <= 10 && dy <= 5) || (dx <= 7 && dy <= 7);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s);
        mdl_t r;
        bit eu, ed, es, eb;
        r = s;
        if (reset) begin
            r.idx = 0; r.locked = 0; r.e_sv = 0; r.e_on = 0; r.e_rgb = 0;
            r.prev_up = 1; r.prev_dn = 1; r.prev_sel = 1; r.prev_bk = 1;
        end else begin
            r.e_on  = cross_hit(int'(pix_x), int'(pix_y), 161, 302 + s.idx * s.ystep);
            r.e_rgb = (video_on && r.e_on) ? (s.locked ? 2 : 4) : 0;
            eu = btn_up   && !s.prev_up;
            ed = btn_down && !s.prev_dn;
            es = btn_sel  && !s.prev_sel;
            eb = btn_back && !s.prev_bk;
            r.e_sv = 0;
            if (!s.locked) begin
                if (es) begin
                    r.locked = 1; r.e_sv = 1;
                end else if (eu && ed) begin
                    r.idx = s.idx;
                end else if (eu) begin
                    r.idx = (s.idx == 0) ? (s.wrap ? s.n - 1 : 0) : s.idx - 1;
                end else if (ed) begin
                    r.idx = (s.idx == s.n - 1) ? (s.wrap ? 0 : s.idx) : s.idx + 1;
                end
            end else if (eb) begin
                r.locked = 0;
            end
            r.prev_up = btn_up; r.prev_dn = btn_down; r.prev_sel = btn_sel; r.prev_bk = btn_back;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input int k, input int nivel, input int locked,
                           input int sv, input int on, input int rgb);
        chk({tag, ".nivel"},      nivel,  m[k].idx);
        chk({tag, ".locked"},     locked, int'(m[k].locked));
        chk({tag, ".sel_valid"},  sv,     int'(m[k].e_sv));
        chk({tag, ".cursor_on"},  on,     int'(m[k].e_on));
        chk({tag, ".cursor_rgb"}, rgb,    m[k].e_rgb);
    endtask

    // one clock: model advances on the edge, all DUTs compared 1 ns later
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m[k] = mdl_step(m[k]);
        #1;
        chk_dut("A", 0, int'(ifa.nivel), int'(ifa.locked), int'(ifa.sel_valid), int'(ifa.cursor_on), int'(ifa.cursor_rgb));
        chk_dut("B", 1, int'(ifb.nivel), int'(ifb.locked), int'(ifb.sel_valid), int'(ifb.cursor_on), int'(ifb.cursor_rgb));
        chk_dut("C", 2, int'(ifc.nivel), int'(ifc.locked), int'(ifc.sel_valid), int'(ifc.cursor_on), int'(ifc.cursor_rgb));
    endtask

    task automatic idle();
        btn_up = 0; btn_down = 0; btn_sel = 0; btn_back = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    // ---------------- hand-derived table for instance A ----------------
    typedef struct {
        bit       up, dn, sel, bk, vid;
        int       px, py;
        int       nivel, locked, sv, on, rgb;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // up dn sel bk vid   px   py   nivel lck sv on rgb
        tbl[0]  = '{0,0,0,0,1, 161, 324, 1, 0, 0, 1, 4};
        tbl[1]  = '{0,0,0,0,1, 151, 324, 1, 0, 0, 0, 0};
        tbl[2]  = '{0,0,0,0,1, 151, 334, 1, 0, 0, 1, 4};
        tbl[3]  = '{1,1,0,0,1, 161, 334, 1, 0, 0, 1, 4};
        tbl[4]  = '{1,1,0,0,1, 168, 341, 1, 0, 0, 1, 4};
        tbl[5]  = '{0,0,0,0,1, 169, 341, 1, 0, 0, 0, 0};
        tbl[6]  = '{0,1,0,0,1, 161, 344, 2, 0, 0, 1, 4};
        tbl[7]  = '{0,0,1,0,1, 161, 366, 2, 1, 1, 1, 4};
        tbl[8]  = '{0,1,0,0,1, 161, 366, 2, 1, 0, 1, 2};
        tbl[9]  = '{0,0,0,0,0, 161, 366, 2, 1, 0, 1, 0};
        tbl[10] = '{0,0,0,1,1, 161, 366, 2, 0, 0, 1, 2};
        tbl[11] = '{0,1,0,0,1, 161, 366, 0, 0, 0, 1, 4};
        tbl[12] = '{1,0,0,0,1, 161, 302, 2, 0, 0, 1, 4};
        tbl[13] = '{0,0,1,1,1,   0,   0, 2, 1, 1, 0, 0};
        tbl[14] = '{0,0,0,0,1,   0,   0, 2, 1, 0, 0, 0};
        tbl[15] = '{0,0,0,1,1,   0,   0, 2, 0, 0, 0, 0};
        tbl[16] = '{0,0,0,0,1,   0,   0, 2, 0, 0, 0, 0};

        m[0] = '{n:3, ystep:32, wrap:1, default:0};
        m[1] = '{n:3, ystep:32, wrap:0, default:0};
        m[2] = '{n:5, ystep:20, wrap:1, default:0};

        idle(); video_on = 1; pix_x = 0; pix_y = 0;

        // reset with down held: no event until released and re-pressed
        reset = 1; btn_down = 1;
        tick(); tick();
        chk("rst.nivel", int'(ifa.nivel), 0);
        chk("rst.locked", int'(ifa.locked), 0);
        chk("rst.cursor_rgb", int'(ifa.cursor_rgb), 0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.nivel", int'(ifa.nivel), 0);
        end
        btn_down = 0; tick();
        chk("release.nivel", int'(ifa.nivel), 0);
        btn_down = 1; tick();
        chk("repress.nivel", int'(ifa.nivel), 1);

        // table-driven pixel / select / back vectors on instance A
        for (int i = 0; i < 17; i++) begin
            btn_up = tbl[i].up; btn_down = tbl[i].dn; btn_sel = tbl[i].sel; btn_back = tbl[i].bk;
            video_on = tbl[i].vid; pix_x = 10'(tbl[i].px); pix_y = 10'(tbl[i].py);
            tick();
            chk($sformatf("tbl%0d.nivel", i),      int'(ifa.nivel),      tbl[i].nivel);
            chk($sformatf("tbl%0d.locked", i),     int'(ifa.locked),     tbl[i].locked);
            chk($sformatf("tbl%0d.sel_valid", i),  int'(ifa.sel_valid),  tbl[i].sv);
            chk($sformatf("tbl%0d.cursor_on", i),  int'(ifa.cursor_on),  tbl[i].on);
            chk($sformatf("tbl%0d.cursor_rgb", i), int'(ifa.cursor_rgb), tbl[i].rgb);
        end

        // up and down together, held for 100 cycles: no movement
        idle(); video_on = 1; tick();
        btn_up = 1; btn_down = 1;
        for (int i = 0; i < 100; i++) tick();
        chk("updown_hold.nivel", int'(ifa.nivel), 2);

        // reset mid-CONFIRMED, then up at 0: wrap vs saturate
        idle(); btn_sel = 1; tick();
        chk("presel.locked", int'(ifa.locked), 1);
        do_reset(); idle(); tick();
        chk("rst_conf.locked", int'(ifa.locked), 0);
        chk("rst_conf.sel_valid", int'(ifa.sel_valid), 0);
        btn_up = 1; tick();
        chk("up0.A", int'(ifa.nivel), 2);
        chk("up0.B", int'(ifb.nivel), 0);
        chk("up0.C", int'(ifc.nivel), 4);

        // five down presses from 0; C cursor geometry at idx 4
        do_reset(); idle(); tick();
        begin
            int exp_a [5] = '{1, 2, 0, 1, 2};
            int exp_b [5] = '{1, 2, 2, 2, 2};
            int exp_c [5] = '{1, 2, 3, 4, 0};
            for (int i = 0; i < 5; i++) begin
                btn_down = 1; tick();
                chk($sformatf("down%0d.A", i), int'(ifa.nivel), exp_a[i]);
                chk($sformatf("down%0d.B", i), int'(ifb.nivel), exp_b[i]);
                chk($sformatf("down%0d.C", i), int'(ifc.nivel), exp_c[i]);
                btn_down = 0;
                if (i == 3) begin
                    pix_x = 10'd161; pix_y = 10'd382; tick();
                    chk("c_idx4.hit", int'(ifc.cursor_on), 1);
                    pix_x = 10'd161; pix_y = 10'd302; tick();
                    chk("c_idx4.miss", int'(ifc.cursor_on), 0);
                end else begin
                    tick();
                end
            end
        end

        // randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) btn_up   = ~btn_up;
            if ($urandom_range(0, 3) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 9) == 0) btn_sel  = ~btn_sel;
            if ($urandom_range(0, 7) == 0) btn_back = ~btn_back;
            video_on = ($urandom_range(0, 7) != 0);
            pix_x    = 10'($urandom_range(145, 177));
            pix_y    = 10'($urandom_range(285, 400));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
